// File: rtl/pid_controller_q.sv
// ============================================================================
// Module      : pid_controller_q
// Description : Strobe-driven fixed-point PID controller. One shared multiplier,
//               output clamp, conditional-integration anti-windup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_controller_q #(
    parameter int DW      = 16,
    parameter int GW      = 16,
    parameter int FRAC    = 8,
    parameter int IW      = 24,
    parameter int OUT_MAX = 2**(DW-1)-1,
    parameter int OUT_MIN = -(2**(DW-1))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clr_integ,
    input  logic signed [DW-1:0] ref_val,
    input  logic signed [DW-1:0] y,
    input  logic signed [GW-1:0] kp,
    input  logic signed [GW-1:0] ki,
    input  logic signed [GW-1:0] kd,
    output logic                 busy,
    output logic signed [DW-1:0] u_out,
    output logic                 u_valid,
    output logic                 sat
);

    localparam int c_aw = GW + IW + 3;
    localparam int c_bw = (IW > DW + 2) ? IW : DW + 2;
    localparam int c_pw = GW + c_bw;
    localparam int c_sw = ((IW > DW + 1) ? IW : DW + 1) + 1;

    localparam longint c_imax_l = (longint'(1) <<< (IW - 1)) - 1;
    localparam logic signed [c_sw-1:0] c_imax = c_sw'(c_imax_l);
    localparam logic signed [c_sw-1:0] c_imin = c_sw'(-c_imax_l - 1);
    localparam logic signed [c_aw-1:0] c_omax = c_aw'(OUT_MAX);
    localparam logic signed [c_aw-1:0] c_omin = c_aw'(OUT_MIN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERR   = 3'd1;
    localparam logic [2:0] S_PTERM = 3'd2;
    localparam logic [2:0] S_ITERM = 3'd3;
    localparam logic [2:0] S_DTERM = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]               r_state, w_next;
    logic signed [DW-1:0]     r_ref, r_y, r_u_out;
    logic signed [GW-1:0]     r_kp, r_ki, r_kd;
    logic signed [DW:0]       r_e, r_e_prev, w_e;
    logic signed [DW+1:0]     r_d, w_d;
    logic signed [IW-1:0]     r_ic, r_integ, w_ic;
    logic signed [c_sw-1:0]   w_sum;
    logic signed [c_aw-1:0]   r_acc, w_prod_ext, w_v;
    logic signed [GW-1:0]     w_ga;
    logic signed [c_bw-1:0]   w_ob;
    logic signed [c_pw-1:0]   w_prod;
    logic signed [DW-1:0]     w_u;
    logic                     w_hi, w_lo, w_hold, w_busy;
    logic                     r_u_valid, r_sat;

    // Error, delta and saturated integrator candidate
    assign w_e   = (DW+1)'(r_ref) - (DW+1)'(r_y);
    assign w_d   = (DW+2)'(w_e) - (DW+2)'(r_e_prev);
    assign w_sum = c_sw'(r_integ) + c_sw'(w_e);
    assign w_ic  = (w_sum > c_imax) ? IW'(c_imax) :
                   (w_sum < c_imin) ? IW'(c_imin) : IW'(w_sum);

    assign w_prod     = c_pw'(w_ga) * c_pw'(w_ob);
    assign w_prod_ext = c_aw'(w_prod);

    assign w_v    = r_acc >>> FRAC;
    assign w_hi   = (w_v > c_omax);
    assign w_lo   = (w_v < c_omin);
    assign w_u    = w_hi ? DW'(OUT_MAX) : w_lo ? DW'(OUT_MIN) : DW'(w_v);
    // Freeze the integrator only when integrating would push further into the clamp
    assign w_hold = (w_hi && !r_e[DW] && (r_e != '0)) || (w_lo && r_e[DW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ERR;
            S_ERR:   w_next = S_PTERM;
            S_PTERM: w_next = S_ITERM;
            S_ITERM: w_next = S_DTERM;
            S_DTERM: w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_ga   = '0;
        w_ob   = '0;
        case (r_state)
            S_PTERM: begin w_ga = r_kp; w_ob = c_bw'(r_e);  end
            S_ITERM: begin w_ga = r_ki; w_ob = c_bw'(r_ic); end
            S_DTERM: begin w_ga = r_kd; w_ob = c_bw'(r_d);  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0; r_y <= '0; r_kp <= '0; r_ki <= '0; r_kd <= '0;
            r_e <= '0; r_d <= '0; r_ic <= '0; r_integ <= '0; r_e_prev <= '0;
            r_acc <= '0; r_u_out <= '0; r_sat <= 1'b0; r_u_valid <= 1'b0;
        end else begin
            r_u_valid <= (r_state == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (clr_integ) begin
                        r_integ  <= '0;
                        r_e_prev <= '0;
                    end
                    if (start) begin
                        r_ref <= ref_val; r_y <= y;
                        r_kp <= kp; r_ki <= ki; r_kd <= kd;
                    end
                end
                S_ERR: begin
                    r_e  <= w_e;
                    r_d  <= w_d;
                    r_ic <= w_ic;
                end
                S_PTERM: r_acc <= w_prod_ext;
                S_ITERM, S_DTERM: r_acc <= r_acc + w_prod_ext;
                S_OUT: begin
                    r_u_out  <= w_u;
                    r_sat    <= w_hi | w_lo;
                    r_e_prev <= r_e;
                    if (!w_hold) r_integ <= r_ic;
                end
                default: ;
            endcase
        end
    end

    assign busy    = w_busy;
    assign u_out   = r_u_out;
    assign u_valid = r_u_valid;
    assign sat     = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_pid_controller_q.sv
// ============================================================================
// Module      : tb_pid_controller_q
// Description : Directed vector bench for pid_controller_q (OUT_MAX=1000).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_controller_q;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               clr_integ = 1'b0;
    logic signed [15:0] ref_val = '0, y = '0;
    logic signed [15:0] kp = '0, ki = '0, kd = '0;
    logic               busy, u_valid, sat;
    logic signed [15:0] u_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic               clr;
        logic signed [15:0] r, yy, gp, gi, gd, eu;
        logic               esat;
    } vec_t;

    vec_t vt[12];

    pid_controller_q #(
        .DW(16), .GW(16), .FRAC(8), .IW(24), .OUT_MAX(1000), .OUT_MIN(-1000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clr_integ(clr_integ),
        .ref_val(ref_val), .y(y), .kp(kp), .ki(ki), .kd(kd),
        .busy(busy), .u_out(u_out), .u_valid(u_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic run_sample(input vec_t v, input string nm);
        int lat, bcnt;
        clr_integ = v.clr; ref_val = v.r; y = v.yy;
        kp = v.gp; ki = v.gi; kd = v.gd; start = 1'b1;
        tick();
        start = 1'b0; clr_integ = 1'b0;
        ref_val = 16'sh1234; y = -16'sd77; kp = 16'sd999; ki = -16'sd5; kd = 16'sd321;
        lat = 0; bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (u_valid) begin lat = k; break; end
            if (busy) bcnt++;
        end
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_busy_cycles"}, bcnt, 5);
        chk({nm, "_u_out"}, u_out, v.eu);
        chk({nm, "_sat"}, sat, v.esat);
        tick();
        chk({nm, "_valid_single"}, u_valid, 0);
    endtask

    initial begin
        int vcount, seen5, seen11;
        vec_t tmp;

        //          clr   ref    y     kp    ki    kd    u      sat
        vt[0]  = '{1'b1, 100,   40,   256,  0,    0,    60,    1'b0};
        vt[1]  = '{1'b1, 10,    0,    0,    128,  0,    5,     1'b0};
        vt[2]  = '{1'b0, 10,    0,    0,    128,  0,    10,    1'b0};
        vt[3]  = '{1'b0, 10,    0,    0,    128,  0,    15,    1'b0};
        vt[4]  = '{1'b1, 10,    0,    0,    128,  0,    5,     1'b0};
        vt[5]  = '{1'b1, 5,     0,    0,    0,    256,  5,     1'b0};
        vt[6]  = '{1'b0, 12,    0,    0,    0,    256,  7,     1'b0};
        vt[7]  = '{1'b0, 0,     3,    128,  0,    0,    -2,    1'b0};
        vt[8]  = '{1'b1, 2000,  0,    256,  256,  0,    1000,  1'b1};
        vt[9]  = '{1'b0, 2000,  0,    256,  256,  0,    1000,  1'b1};
        vt[10] = '{1'b0, 1,     0,    0,    256,  0,    1,     1'b0};
        vt[11] = '{1'b1, 0,     2000, 256,  0,    0,    -1000, 1'b1};

        tick(); tick();
        chk("reset_u_out", u_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", u_valid, 0);
        chk("reset_sat", sat, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++)
            run_sample(vt[i], $sformatf("vec%0d", i));

        // Overlapping starts: only the first and the one at +6 are accepted
        vcount = 0; seen5 = 0; seen11 = 0;
        kp = 256; ki = 0; kd = 0;
        for (int c = 0; c <= 14; c++) begin
            start     = (c == 0) || (c == 2) || (c == 6);
            clr_integ = (c == 0);
            ref_val   = (c == 2) ? 16'sd300 : (c == 6) ? 16'sd200 : 16'sd100;
            y         = (c == 6) ? 16'sd0 : 16'sd40;
            tick();
            start = 1'b0; clr_integ = 1'b0;
            if (u_valid) begin
                vcount++;
                if (c == 5)  begin seen5 = 1;  chk("hs_first_u_out", u_out, 60); end
                if (c == 11) begin seen11 = 1; chk("hs_third_u_out", u_out, 200); end
            end
        end
        chk("hs_valid_count", vcount, 2);
        chk("hs_valid_at_5", seen5, 1);
        chk("hs_valid_at_11", seen11, 1);

        // Reset mid-computation after loading the integrator
        tmp = '{1'b1, 50, 0, 0, 256, 0, 50, 1'b0};
        run_sample(tmp, "preload");
        ref_val = 50; y = 0; kp = 0; ki = 256; kd = 0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_u_out", u_out, 0);
        chk("midrst_sat", sat, 0);
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) rst = 1'b0;
            tick();
            if (u_valid) vcount++;
        end
        chk("midrst_no_valid", vcount, 0);
        tmp = '{1'b0, 1, 0, 0, 256, 0, 1, 1'b0};
        run_sample(tmp, "postrst_integ");
        run_sample(vt[0], "postrst_p");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/pid_controller_q.md
Name: pid_controller_q

Overview:
Parametrised fixed-point PID controller, the successor to the fixed-gain PID block in the SoC control subsystem. Gains are runtime Q-format inputs. Computation is strobe-driven and time-shares one multiplier through a small FSM. It adds output saturation, integrator anti-windup, integrator clear and a valid/busy handshake toward the actuator interface.

Parameters:
DW, 16, signed width of ref, y and u_out
GW, 16, signed width of kp/ki/kd
FRAC, 8, fractional bits of the gains (Q(GW-FRAC).FRAC)
IW, 24, signed width of the integrator register
OUT_MAX, 2**(DW-1)-1, upper output clamp (signed, DW bits)
OUT_MIN, -2**(DW-1), lower output clamp (signed, DW bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  sample strobe; accepted only in IDLE
clr_integ  in  1  clear integrator and e_prev; honoured only in IDLE
ref  in  DW  signed setpoint, latched on accepted start
y  in  DW  signed measurement, latched on accepted start
kp, ki, kd  in  GW each  signed Q gains, latched on accepted start
busy  out  1  high while FSM not in IDLE
u_out  out  DW  signed control output, held between samples
u_valid  out  1  one-cycle pulse when u_out updates
sat  out  1  high if the latest u_out was clamped; held with u_out

Behaviour:
- Reset: state IDLE; u_out, u_valid, busy, sat, integ, e_prev, acc and latched operands all 0.
- FSM: IDLE -> ERR -> PTERM -> ITERM -> DTERM -> OUT -> IDLE. One state per clock.
- IDLE: start=1 latches ref, y, kp, ki, kd and moves to ERR. clr_integ=1 zeroes integ and e_prev. If clr_integ and start are both high, the clear applies first, so the sample sees integ=0 and e_prev=0.
- ERR: e = ref - y in DW+1 bits, no overflow. d = e - e_prev in DW+2 bits. ic = integ + e, saturated to the IW signed range. All three are registered.
- PTERM: acc = kp*e. ITERM: acc += ki*ic. DTERM: acc += kd*d.
- acc width is GW+IW+3 bits, signed. No intermediate overflow is permitted.
- OUT: v = acc >>> FRAC (arithmetic shift, floor toward -inf). u_out = clamp(v, OUT_MIN, OUT_MAX). sat = (v != u_out). u_valid = 1 for this single cycle. e_prev <= e.
- Anti-windup (conditional integration): integ <= ic, except when v > OUT_MAX with e > 0, or v < OUT_MIN with e < 0. In those cases integ is held.
- Latency: start sampled at edge N; u_out, u_valid and sat update at edge N+5.
- busy is high after edges N..N+4 and falls at N+5.
- Next start is accepted at edge N+6 or later, so maximum throughput is one sample per 6 cycles.
- start while busy is ignored and not queued. clr_integ while busy is ignored.
- Inputs are not sampled after start is accepted, so changes to ref, y or the gains mid-computation have no effect.
- Reset mid-computation: immediate return to the reset state; no u_valid pulse.
- u_valid is never high for two consecutive cycles.

Test Plan:
- P only (FRAC=8): kp=256, ki=kd=0, ref=100, y=40, start pulse -> u_out=60, sat=0, u_valid one cycle exactly 5 cycles after start, busy high 5 cycles.
- I accumulation: kp=0, ki=128, kd=0, ref=10, y=0, three starts spaced 6 cycles -> u_out 5, 10, 15. Then a start with clr_integ=1 -> u_out=5.
- D and negative floor: kd=256, others 0, samples with e=5 then e=12 -> u_out 5 then 7. Then kp=128 only with e=-3 -> u_out=-2.
- Saturation and anti-windup: OUT_MAX=1000, kp=ki=256, ref=2000, y=0, two starts -> u_out=1000 and sat=1 both times. integ stays 0, so the second acc equals the first.
- Handshake: start at N, again at N+2 and N+6 -> second start ignored, third accepted. u_valid at N+5 and N+11 only.
- Reset mid-op: assert rst at N+3 -> no u_valid. u_out, busy, sat and integ return to 0. A fresh start after release behaves as in the P-only scenario.
